// File: rtl/updown_count_ctrl.sv
// Bounded up/down counter driven by two asynchronous debounced button levels.
// Define AUTOREPEAT_EN to build the hold-to-repeat stepping FSM.
module updown_count_ctrl #(
    parameter int WIDTH         = 4,
    parameter int MAX_VAL       = 9,
    parameter int WRAP          = 1,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_a_p,
    input  logic             up_in,
    input  logic             down_in,
    input  logic             enable,
    output logic [WIDTH-1:0] count_out,
    output logic             at_max,
    output logic             at_min,
    output logic             count_pulse
);

    if (MAX_VAL < 1 || MAX_VAL >= (1 << WIDTH) || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1)
    begin : g_param_check
        $error("updown_count_ctrl: invalid parameter combination");
    end

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

    logic up_s1_q, up_s2_q, up_s3_q;
    logic down_s1_q, down_s2_q, down_s3_q;
    logic [1:0] warm_q;
    logic warm_done;

    // Rises are ignored until the history flop holds real input data, so a button
    // held through reset does not step when reset is released.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            up_s1_q   <= 1'b0;
            up_s2_q   <= 1'b0;
            up_s3_q   <= 1'b0;
            down_s1_q <= 1'b0;
            down_s2_q <= 1'b0;
            down_s3_q <= 1'b0;
            warm_q    <= 2'd0;
        end else begin
            up_s1_q   <= up_in;
            up_s2_q   <= up_s1_q;
            up_s3_q   <= up_s2_q;
            down_s1_q <= down_in;
            down_s2_q <= down_s1_q;
            down_s3_q <= down_s2_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    assign warm_done = (warm_q == 2'd3);

    logic up_rise, down_rise;
    logic up_rise_step, down_rise_step;
    logic both_held;
    logic up_step, down_step;

    assign up_rise        = up_s2_q & ~up_s3_q & warm_done;
    assign down_rise      = down_s2_q & ~down_s3_q & warm_done;
    assign up_rise_step   = up_rise & ~down_s2_q;
    assign down_rise_step = down_rise & ~up_s2_q;
    assign both_held      = up_s2_q & down_s2_q;

`ifdef AUTOREPEAT_EN
    localparam int TimerMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TimerW   = (TimerMax > 2) ? $clog2(TimerMax) : 1;
    localparam logic [TimerW-1:0] HoldLoad   = TimerW'(HOLD_CYCLES - 1);
    localparam logic [TimerW-1:0] RepeatLoad = TimerW'(REPEAT_CYCLES - 1);
    localparam logic [TimerW-1:0] TimerOne   = TimerW'(1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StHold   = 2'd1;
    localparam logic [1:0] StRepeat = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              dir_up_q, dir_up_d;
    logic              track_held;

    assign track_held = dir_up_q ? up_s2_q : down_s2_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        dir_up_d  = dir_up_q;
        up_step   = 1'b0;
        down_step = 1'b0;
        if (!enable || both_held) begin
            state_d = StIdle;
            timer_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (up_rise_step) begin
                        up_step  = 1'b1;
                        dir_up_d = 1'b1;
                        timer_d  = HoldLoad;
                        state_d  = StHold;
                    end else if (down_rise_step) begin
                        down_step = 1'b1;
                        dir_up_d  = 1'b0;
                        timer_d   = HoldLoad;
                        state_d   = StHold;
                    end
                end
                StHold, StRepeat: begin
                    if (!track_held) begin
                        state_d = StIdle;
                        timer_d = '0;
                    end else if (timer_q == '0) begin
                        up_step   = dir_up_q;
                        down_step = ~dir_up_q;
                        timer_d   = RepeatLoad;
                        state_d   = StRepeat;
                    end else begin
                        timer_d = timer_q - TimerOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            dir_up_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_up_q <= dir_up_d;
        end
    end
`else
    assign up_step   = enable & up_rise_step;
    assign down_step = enable & down_rise_step;
`endif

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_max_q, at_min_q, pulse_q;

    always_comb begin
        count_d = count_q;
        if (up_step) begin
            if (count_q == MaxCount) begin
                count_d = (WRAP != 0) ? '0 : MaxCount;
            end else begin
                count_d = count_q + CountOne;
            end
        end else if (down_step) begin
            if (count_q == '0) begin
                count_d = (WRAP != 0) ? MaxCount : '0;
            end else begin
                count_d = count_q - CountOne;
            end
        end
    end

    // Flags and strobe derive from count_d so they line up with count_out.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            count_q  <= '0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
            pulse_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            at_max_q <= (count_d == MaxCount);
            at_min_q <= (count_d == '0);
            pulse_q  <= (count_d != count_q);
        end
    end

    assign count_out   = count_q;
    assign at_max      = at_max_q;
    assign at_min      = at_min_q;
    assign count_pulse = pulse_q;

endmodule
